// File: rtl/doorway_occupancy_ctrl.sv
// Doorway occupancy controller: classifies beam crossings as enter/exit, keeps a
// saturating head count and drives the room lamp with off-delay and manual override.
module doorway_occupancy_ctrl #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned MAX_OCC   = 200,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned OFF_DELAY = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_x1,
    input  logic             i_x2,
    input  logic             i_force_on,
    input  logic             i_force_off,
    output logic [CNT_W-1:0] o_occ_count,
    output logic             o_lamp,
    output logic             o_enter_pulse,
    output logic             o_exit_pulse,
    output logic             o_err
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam int unsigned DLY_W = $clog2(OFF_DELAY + 1);

    typedef enum logic [1:0] {
        StIdle,
        StOutSeen,
        StInSeen,
        StWaitClr
    } state_e;

    logic             r_x1_q, r_x1_qq, r_x2_q, r_x2_qq;
    logic             w_rise1, w_rise2;
    state_e           r_state, w_state_d;
    logic [TMR_W-1:0] r_tmr, w_tmr_d;
    logic             w_enter, w_exit, w_both;
    logic [CNT_W-1:0] r_occ, w_occ_d;
    logic             r_enter, r_exit, r_err, w_err_d;
    logic [DLY_W-1:0] r_off_tmr, w_off_d;
    logic             r_was_nz;
    logic             r_lamp, w_auto, w_lamp_d;

    assign w_rise1 = r_x1_q & ~r_x1_qq;
    assign w_rise2 = r_x2_q & ~r_x2_qq;

    always_comb begin
        w_state_d = r_state;
        w_tmr_d   = r_tmr;
        w_enter   = 1'b0;
        w_exit    = 1'b0;
        w_both    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_rise1 && w_rise2) begin
                    w_state_d = StWaitClr;
                    w_both    = 1'b1;
                end else if (w_rise1) begin
                    w_state_d = StOutSeen;
                    w_tmr_d   = '0;
                end else if (w_rise2) begin
                    w_state_d = StInSeen;
                    w_tmr_d   = '0;
                end
            end
            StOutSeen: begin
                if (w_rise2) begin
                    w_state_d = StWaitClr;
                    w_enter   = 1'b1;
                end else if (w_rise1) begin
                    w_tmr_d = '0;
                end else if (r_tmr == TMR_W'(TIMEOUT - 1)) begin
                    w_state_d = StWaitClr;
                end else begin
                    w_tmr_d = r_tmr + TMR_W'(1);
                end
            end
            StInSeen: begin
                if (w_rise1) begin
                    w_state_d = StWaitClr;
                    w_exit    = 1'b1;
                end else if (w_rise2) begin
                    w_tmr_d = '0;
                end else if (r_tmr == TMR_W'(TIMEOUT - 1)) begin
                    w_state_d = StWaitClr;
                end else begin
                    w_tmr_d = r_tmr + TMR_W'(1);
                end
            end
            StWaitClr: begin
                if (!r_x1_q && !r_x2_q) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Pulses still fire on saturation; only the count holds.
    always_comb begin
        w_occ_d = r_occ;
        w_err_d = w_both;
        if (w_enter) begin
            if (r_occ < CNT_W'(MAX_OCC)) w_occ_d = r_occ + CNT_W'(1);
            else                         w_err_d = 1'b1;
        end else if (w_exit) begin
            if (r_occ != '0) w_occ_d = r_occ - CNT_W'(1);
            else             w_err_d = 1'b1;
        end
    end

    // Off-delay runs regardless of the force inputs so auto mode resumes coherently.
    always_comb begin
        w_off_d = r_off_tmr;
        w_auto  = 1'b0;
        if (r_occ != '0) begin
            w_off_d = '0;
            w_auto  = 1'b1;
        end else if (r_was_nz) begin
            w_off_d = DLY_W'(OFF_DELAY);
            w_auto  = 1'b1;
        end else if (r_off_tmr != '0) begin
            w_off_d = r_off_tmr - DLY_W'(1);
            w_auto  = (r_off_tmr > DLY_W'(1));
        end
        if (i_force_off)     w_lamp_d = 1'b0;
        else if (i_force_on) w_lamp_d = 1'b1;
        else                 w_lamp_d = w_auto;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x1_q    <= 1'b0;
            r_x1_qq   <= 1'b0;
            r_x2_q    <= 1'b0;
            r_x2_qq   <= 1'b0;
            r_state   <= StIdle;
            r_tmr     <= '0;
            r_occ     <= '0;
            r_enter   <= 1'b0;
            r_exit    <= 1'b0;
            r_err     <= 1'b0;
            r_off_tmr <= '0;
            r_was_nz  <= 1'b0;
            r_lamp    <= 1'b0;
        end else begin
            r_x1_q    <= i_x1;
            r_x1_qq   <= r_x1_q;
            r_x2_q    <= i_x2;
            r_x2_qq   <= r_x2_q;
            r_state   <= w_state_d;
            r_tmr     <= w_tmr_d;
            r_occ     <= w_occ_d;
            r_enter   <= w_enter;
            r_exit    <= w_exit;
            r_err     <= w_err_d;
            r_off_tmr <= w_off_d;
            r_was_nz  <= (r_occ != '0);
            r_lamp    <= w_lamp_d;
        end
    end

    assign o_occ_count   = r_occ;
    assign o_lamp        = r_lamp;
    assign o_enter_pulse = r_enter;
    assign o_exit_pulse  = r_exit;
    assign o_err         = r_err;

endmodule

// File: tb/tb_doorway_occupancy_ctrl.sv
// Randomized and directed bench for doorway_occupancy_ctrl against a behavioural
// model of crossings, saturating count and lamp off-delay.
module tb_doorway_occupancy_ctrl;

    localparam int MAX_OCC   = 5;
    localparam int TIMEOUT   = 16;
    localparam int OFF_DELAY = 32;

    typedef logic [3:0] vec_t;  // {force_off, force_on, x2, x1}

    logic       clk, rst, x1, x2, fon, foff;
    logic [7:0] occ;
    logic       lamp, enter_p, exit_p, err;

    int n_vec = 0;
    int n_bad = 0;

    // Model state: ph 0 none pending, 1 outer first, 2 inner first, 3 waiting for clear
    int   m_ph, m_age, m_cnt, m_zc;
    logic m_x1q, m_x1qq, m_x2q, m_x2qq;
    logic e_enter, e_exit, e_err, e_lamp;

    vec_t g_stim[$];

    doorway_occupancy_ctrl #(
        .CNT_W    (8),
        .MAX_OCC  (MAX_OCC),
        .TIMEOUT  (TIMEOUT),
        .OFF_DELAY(OFF_DELAY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_x1         (x1),
        .i_x2         (x2),
        .i_force_on   (fon),
        .i_force_off  (foff),
        .o_occ_count  (occ),
        .o_lamp       (lamp),
        .o_enter_pulse(enter_p),
        .o_exit_pulse (exit_p),
        .o_err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] obs();
        return {occ, lamp, enter_p, exit_p, err};
    endfunction

    function automatic logic [11:0] expv();
        return {8'(m_cnt), e_lamp, e_enter, e_exit, e_err};
    endfunction

    function automatic void seg(input vec_t v, input int n);
        repeat (n) g_stim.push_back(v);
    endfunction

    function automatic void add_enter();
        seg(4'b0001, 3); seg(4'b0011, 2); seg(4'b0010, 2); seg(4'b0000, 3);
    endfunction

    function automatic void add_exit();
        seg(4'b0010, 3); seg(4'b0011, 2); seg(4'b0001, 2); seg(4'b0000, 3);
    endfunction

    task automatic model_reset();
        m_ph = 0; m_age = 0; m_cnt = 0; m_zc = OFF_DELAY + 1;
        m_x1q = 0; m_x1qq = 0; m_x2q = 0; m_x2qq = 0;
        e_enter = 0; e_exit = 0; e_err = 0; e_lamp = 0;
    endtask

    task automatic model_step();
        logic r1, r2;
        int   old_cnt;
        r1 = m_x1q & ~m_x1qq;
        r2 = m_x2q & ~m_x2qq;
        old_cnt = m_cnt;
        e_enter = 0; e_exit = 0; e_err = 0;
        case (m_ph)
            0: if (r1 && r2) begin m_ph = 3; e_err = 1; end
               else if (r1) begin m_ph = 1; m_age = 0; end
               else if (r2) begin m_ph = 2; m_age = 0; end
            1: if (r2) begin m_ph = 3; e_enter = 1; end
               else if (r1) m_age = 0;
               else if (m_age == TIMEOUT - 1) m_ph = 3;
               else m_age++;
            2: if (r1) begin m_ph = 3; e_exit = 1; end
               else if (r2) m_age = 0;
               else if (m_age == TIMEOUT - 1) m_ph = 3;
               else m_age++;
            default: if (!m_x1q && !m_x2q) m_ph = 0;
        endcase
        if (e_enter) begin
            if (m_cnt < MAX_OCC) m_cnt++; else e_err = 1;
        end
        if (e_exit) begin
            if (m_cnt > 0) m_cnt--; else e_err = 1;
        end
        // Lamp sees the count one edge late; zc = consecutive zero samples.
        if (old_cnt != 0) m_zc = 0;
        else if (m_zc <= OFF_DELAY) m_zc++;
        if (foff)     e_lamp = 0;
        else if (fon) e_lamp = 1;
        else          e_lamp = (old_cnt != 0) || (m_zc <= OFF_DELAY);
        m_x1qq = m_x1q; m_x1q = x1;
        m_x2qq = m_x2q; m_x2q = x2;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        {foff, fon, x2, x1} = 4'b0000;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (obs() !== 12'h000) begin
            n_bad++; $display("FAIL reset outputs: got %h want 000", obs());
        end
        g_stim.delete(); seg(4'b0000, 5);
        foreach (g_stim[k]) begin
            {foff, fon, x2, x1} = g_stim[k]; tick(); n_vec++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL reset idle cyc %0d: got %h want %h", k, obs(), expv());
            end
        end
    endtask

    task automatic test_enter();
        int enters = 0;
        int first_lamp = -1, cnt_at = -1;
        do_reset();
        g_stim.delete(); add_enter(); seg(4'b0000, 3);
        foreach (g_stim[k]) begin
            {foff, fon, x2, x1} = g_stim[k]; tick(); n_vec++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL enter cyc %0d: got %h want %h", k, obs(), expv());
            end
            enters += int'(enter_p);
            if (occ == 8'd1 && cnt_at < 0) cnt_at = k;
            if (lamp && first_lamp < 0) first_lamp = k;
        end
        n_vec++;
        if (enters !== 1 || occ !== 8'd1) begin
            n_bad++; $display("FAIL enter count: got pulses %0d count %0d want 1 1", enters, occ);
        end
        n_vec++;
        if (first_lamp !== cnt_at + 1) begin
            n_bad++; $display("FAIL enter lamp lag: got cyc %0d want %0d", first_lamp, cnt_at + 1);
        end
    endtask

    task automatic test_exit();
        int lamp_after = 0, seen = 0, dropped = 0, exits = 0;
        do_reset();
        g_stim.delete(); add_enter(); add_exit(); seg(4'b0000, 40);
        foreach (g_stim[k]) begin
            {foff, fon, x2, x1} = g_stim[k]; tick(); n_vec++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL exit cyc %0d: got %h want %h", k, obs(), expv());
            end
            if (seen && lamp) lamp_after++;
            if (exit_p) begin seen = 1; exits++; end
        end
        n_vec++;
        if (exits !== 1 || occ !== 8'd0 || lamp_after !== OFF_DELAY) begin
            n_bad++;
            $display("FAIL exit delay: got exits %0d count %0d lamp %0d want 1 0 %0d",
                     exits, occ, lamp_after, OFF_DELAY);
        end
        seen = 0;
        g_stim.delete(); add_enter(); add_exit(); seg(4'b0000, 15); add_enter(); seg(4'b0000, 40);
        foreach (g_stim[k]) begin
            {foff, fon, x2, x1} = g_stim[k]; tick(); n_vec++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL exit reentry cyc %0d: got %h want %h", k, obs(), expv());
            end
            if (seen && !lamp) dropped = 1;
            if (lamp) seen = 1;
        end
        n_vec++;
        if (dropped !== 0 || occ !== 8'd1) begin
            n_bad++; $display("FAIL exit reentry lamp: got drop %0d count %0d want 0 1", dropped, occ);
        end
    endtask

    task automatic test_timeout();
        int events = 0;
        do_reset();
        g_stim.delete(); add_enter();
        seg(4'b0001, 20); seg(4'b0011, 5); seg(4'b0010, 4); seg(4'b0000, 4);
        foreach (g_stim[k]) begin
            {foff, fon, x2, x1} = g_stim[k]; tick(); n_vec++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL timeout cyc %0d: got %h want %h", k, obs(), expv());
            end
            if (k >= 10) events += int'(enter_p) + int'(exit_p);
        end
        n_vec++;
        if (events !== 0 || occ !== 8'd1) begin
            n_bad++; $display("FAIL timeout: got events %0d count %0d want 0 1", events, occ);
        end
    endtask

    task automatic test_bounds();
        int errs_in = 0, errs_out = 0, enters = 0, exits = 0;
        do_reset();
        g_stim.delete();
        repeat (MAX_OCC + 1) add_enter();
        foreach (g_stim[k]) begin
            {foff, fon, x2, x1} = g_stim[k]; tick(); n_vec++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL bounds up cyc %0d: got %h want %h", k, obs(), expv());
            end
            errs_in += int'(err); enters += int'(enter_p);
        end
        n_vec++;
        if (occ !== 8'(MAX_OCC) || errs_in !== 1 || enters !== MAX_OCC + 1) begin
            n_bad++;
            $display("FAIL bounds ceiling: got count %0d err %0d pulses %0d want %0d 1 %0d",
                     occ, errs_in, enters, MAX_OCC, MAX_OCC + 1);
        end
        g_stim.delete();
        repeat (MAX_OCC + 1) add_exit();
        foreach (g_stim[k]) begin
            {foff, fon, x2, x1} = g_stim[k]; tick(); n_vec++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL bounds down cyc %0d: got %h want %h", k, obs(), expv());
            end
            errs_out += int'(err); exits += int'(exit_p);
        end
        n_vec++;
        if (occ !== 8'd0 || errs_out !== 1 || exits !== MAX_OCC + 1) begin
            n_bad++;
            $display("FAIL bounds floor: got count %0d err %0d pulses %0d want 0 1 %0d",
                     occ, errs_out, exits, MAX_OCC + 1);
        end
    endtask

    task automatic test_simul_force();
        int errs = 0, events = 0;
        do_reset();
        g_stim.delete(); seg(4'b0011, 3); seg(4'b0000, 3);
        foreach (g_stim[k]) begin
            {foff, fon, x2, x1} = g_stim[k]; tick(); n_vec++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL simul cyc %0d: got %h want %h", k, obs(), expv());
            end
            errs += int'(err); events += int'(enter_p) + int'(exit_p);
        end
        n_vec++;
        if (errs !== 1 || events !== 0) begin
            n_bad++; $display("FAIL simul: got err %0d events %0d want 1 0", errs, events);
        end
        g_stim.delete(); add_enter(); add_enter(); seg(4'b1000, 3);
        foreach (g_stim[k]) begin
            {foff, fon, x2, x1} = g_stim[k]; tick(); n_vec++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL force_off cyc %0d: got %h want %h", k, obs(), expv());
            end
        end
        n_vec++;
        if (lamp !== 1'b0 || occ !== 8'd2) begin
            n_bad++; $display("FAIL force_off: got lamp %0d count %0d want 0 2", lamp, occ);
        end
        g_stim.delete(); add_exit(); add_exit(); seg(4'b0000, 40); seg(4'b0100, 3);
        foreach (g_stim[k]) begin
            {foff, fon, x2, x1} = g_stim[k]; tick(); n_vec++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL force_on cyc %0d: got %h want %h", k, obs(), expv());
            end
        end
        n_vec++;
        if (lamp !== 1'b1 || occ !== 8'd0) begin
            n_bad++; $display("FAIL force_on: got lamp %0d count %0d want 1 0", lamp, occ);
        end
        {foff, fon, x2, x1} = 4'b1100; tick(); tick(); n_vec++;
        if (lamp !== 1'b0) begin
            n_bad++; $display("FAIL force_both: got lamp %0d want 0", lamp);
        end
    endtask

    task automatic test_rst_mid();
        int enters = 0;
        do_reset();
        g_stim.delete(); repeat (5) add_enter(); seg(4'b0001, 3);
        foreach (g_stim[k]) begin
            {foff, fon, x2, x1} = g_stim[k]; tick(); n_vec++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL rst_mid setup cyc %0d: got %h want %h", k, obs(), expv());
            end
        end
        #2 rst = 1'b1;
        #1 n_vec++;
        if (obs() !== 12'h000) begin
            n_bad++; $display("FAIL rst_mid async: got %h want 000", obs());
        end
        {foff, fon, x2, x1} = 4'b0000;
        repeat (2) @(posedge clk);
        #1 model_reset();
        rst = 1'b0;
        g_stim.delete(); seg(4'b0010, 3); seg(4'b0000, 25);
        foreach (g_stim[k]) begin
            {foff, fon, x2, x1} = g_stim[k]; tick(); n_vec++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL rst_mid after cyc %0d: got %h want %h", k, obs(), expv());
            end
            enters += int'(enter_p);
        end
        n_vec++;
        if (enters !== 0 || occ !== 8'd0) begin
            n_bad++; $display("FAIL rst_mid: got enters %0d count %0d want 0 0", enters, occ);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 4) == 0) x1 = ~x1;
            if ($urandom_range(0, 4) == 0) x2 = ~x2;
            foff = ($urandom_range(0, 29) == 0);
            fon  = ($urandom_range(0, 19) == 0);
            tick(); n_vec++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL random cyc %0d: got %h want %h", k, obs(), expv());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        {foff, fon, x2, x1} = 4'b0000;
        model_reset();
        test_reset();
        test_enter();
        test_exit();
        test_timeout();
        test_bounds();
        test_simul_force();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
